// File: rtl/sm2_modop_arbiter.sv
// sm2_modop_arbiter: round-robin sharing of one modular arithmetic unit among SM2 requesters,
// with operand latching, start/done handshake, watchdog abort and one-hot result delivery.
module sm2_modop_arbiter #(
  parameter int W       = 256,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [W*N_REQ-1:0] op_a,
  input  logic [W*N_REQ-1:0] op_b,
  input  logic [W*N_REQ-1:0] op_n,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       res,
  output logic [N_REQ-1:0]   res_valid,
  output logic               res_err,
  output logic [W-1:0]       unit_a,
  output logic [W-1:0]       unit_b,
  output logic [W-1:0]       unit_n,
  output logic               unit_start,
  output logic               unit_abort,
  input  logic [W-1:0]       unit_res,
  input  logic               unit_done
);
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [LW-1:0] w_q, w_d, last_q, last_d, win, cand;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rv_q, rv_d;
  logic err_q, err_d;
  logic [W-1:0] res_q, res_d, a_q, a_d, b_q, b_d, n_q, n_d;
  logic grab, done_w, abort, expired;
  // Scan downward so the candidate closest to last+1 is written last and wins.
  always_comb begin
    win = last_q;
    cand = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = LW'((int'(last_q) + k) % N_REQ);
      if (req[cand]) win = cand;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      last_q  <= LW'(N_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      rv_q    <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = |req ? START : IDLE;
      START:   state_d = WAIT;
      WAIT:    state_d = (unit_done || expired) ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
  end
  // The watchdog stops counting at TIMEOUT-1 so it saturates on the abort cycle.
  always_comb begin
    grab    = (state_q == IDLE) && |req;
    expired = cnt_q == CW'(TIMEOUT - 1);
    done_w  = (state_q == WAIT) && unit_done;
    abort   = (state_q == WAIT) && !unit_done && expired;
    w_d     = grab ? win : w_q;
    last_d  = (state_q == RESP) ? w_q : last_q;
    gnt_d   = grab ? N_REQ'(1) << win : (state_q == RESP) ? '0 : gnt_q;
    a_d     = grab ? op_a[int'(win)*W +: W] : a_q;
    b_d     = grab ? op_b[int'(win)*W +: W] : b_q;
    n_d     = grab ? op_n[int'(win)*W +: W] : n_q;
    cnt_d   = (state_q == START) ? '0 : (state_q == WAIT && !expired) ? cnt_q + CW'(1) : cnt_q;
    res_d   = done_w ? unit_res : abort ? '0 : res_q;
    err_d   = abort;
    rv_d    = (done_w || abort) ? N_REQ'(1) << w_q : '0;
  end
  always_comb begin
    unit_start = state_q == START;
    unit_abort = abort;
    gnt        = gnt_q;
    res        = res_q;
    res_valid  = rv_q;
    res_err    = err_q;
    unit_a     = a_q;
    unit_b     = b_q;
    unit_n     = n_q;
  end
endmodule
